// File: rtl/raw2rgb_pkg.sv
// Shared types and constants for the raw-to-RGB front end and debayer.
package raw2rgb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    HBLANK,
    VBLANK
  } sched_state_t;

  localparam int unsigned PIX_CNT_W   = 12;
  localparam int unsigned LINE_CNT_W  = 12;
  localparam int unsigned BLANK_CNT_W = 16;

  localparam int unsigned DEFAULT_IMG_W = 1280;
  localparam int unsigned DEFAULT_IMG_H = 720;

endpackage

// File: rtl/raw2rgb_blank_timer.sv
// Loadable down-counter that parks at zero; times both horizontal and vertical blanking.
module raw2rgb_blank_timer
  import raw2rgb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [BLANK_CNT_W-1:0] load_val_i,
  output logic                   zero_o
);

  logic [BLANK_CNT_W-1:0] cnt_q;

  // Load wins over counting; otherwise decrement until zero and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - BLANK_CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/raw2rgb_line_sched.sv
// Re-frames the capture pixel stream into per-line packets and enforces line/frame blanking.
module raw2rgb_line_sched
  import raw2rgb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = DEFAULT_IMG_W,
  parameter int unsigned IMG_H      = DEFAULT_IMG_H,
  parameter int unsigned MIN_HBLANK = 16,
  parameter int unsigned MIN_VBLANK = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  output logic [11:0]           line_idx,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  sync_err
);

  localparam logic [PIX_CNT_W-1:0]   PixLast    = PIX_CNT_W'(IMG_W - 1);
  localparam logic [LINE_CNT_W-1:0]  LineLast   = LINE_CNT_W'(IMG_H - 1);
  localparam logic [BLANK_CNT_W-1:0] HblankLoad = BLANK_CNT_W'(MIN_HBLANK - 1);
  localparam logic [BLANK_CNT_W-1:0] VblankLoad = BLANK_CNT_W'(MIN_VBLANK - 1);

  sched_state_t state_q, state_d;

  logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_CNT_W-1:0] line_q, line_d;
  logic [DATA_WIDTH-1:0] raw_data_q, raw_data_d;
  logic raw_valid_q, raw_valid_d;
  logic raw_sop_q, raw_sop_d;
  logic raw_eop_q, raw_eop_d;
  logic frame_done_q, frame_done_d;
  logic sync_err_q, sync_err_d;
  logic busy_q, busy_d;
  logic in_ready_q, in_ready_d;

  logic                   tmr_load;
  logic [BLANK_CNT_W-1:0] tmr_val;
  logic                   tmr_zero;
  logic                   beat;

  assign beat = in_valid & in_ready_q;

  raw2rgb_blank_timer u_blank_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, counter and output decode for the line scheduler.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_d       = line_q;
    raw_data_d   = raw_data_q;
    raw_valid_d  = 1'b0;
    raw_sop_d    = 1'b0;
    raw_eop_d    = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      IDLE: begin
        // Only a start-of-frame beat opens a frame; anything else is drained silently.
        if (beat && in_sof) begin
          raw_valid_d = 1'b1;
          raw_data_d  = in_data;
          raw_sop_d   = 1'b1;
          line_d      = '0;
          if (IMG_W == 1) begin
            raw_eop_d = 1'b1;
            pix_cnt_d = '0;
            tmr_load  = 1'b1;
            if (IMG_H > 1) begin
              state_d = HBLANK;
              tmr_val = HblankLoad;
            end else begin
              state_d = VBLANK;
              tmr_val = VblankLoad;
            end
          end else begin
            pix_cnt_d = PIX_CNT_W'(1);
            state_d   = LINE;
          end
        end
      end

      LINE: begin
        if (beat) begin
          if (in_sof && (pix_cnt_q != '0 || line_q != '0)) begin
            // Misplaced frame start: abandon the frame without closing the line.
            sync_err_d = 1'b1;
            pix_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            raw_valid_d = 1'b1;
            raw_data_d  = in_data;
            raw_sop_d   = (pix_cnt_q == '0);
            if (pix_cnt_q == PixLast) begin
              raw_eop_d = 1'b1;
              pix_cnt_d = '0;
              tmr_load  = 1'b1;
              if (line_q < LineLast) begin
                state_d = HBLANK;
                tmr_val = HblankLoad;
              end else begin
                state_d = VBLANK;
                tmr_val = VblankLoad;
              end
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
            end
          end
        end
      end

      HBLANK: begin
        if (tmr_zero) begin
          state_d = LINE;
          line_d  = line_q + LINE_CNT_W'(1);
        end
      end

      VBLANK: begin
        if (tmr_zero) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // in_ready is registered, so it is decoded from the state we are entering.
    case (state_d)
      IDLE:    in_ready_d = enable;
      LINE:    in_ready_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      line_q       <= '0;
      raw_data_q   <= '0;
      raw_valid_q  <= 1'b0;
      raw_sop_q    <= 1'b0;
      raw_eop_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_q       <= line_d;
      raw_data_q   <= raw_data_d;
      raw_valid_q  <= raw_valid_d;
      raw_sop_q    <= raw_sop_d;
      raw_eop_q    <= raw_eop_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign raw_data   = raw_data_q;
  assign raw_valid  = raw_valid_q;
  assign raw_sop    = raw_sop_q;
  assign raw_eop    = raw_eop_q;
  assign line_idx   = line_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign sync_err   = sync_err_q;

endmodule
